serial_alu_unit: RTL

- Parametrised serial execution unit for the mini serial processor. Successor to the fixed 32-bit ALU/shifter packet endpoints.
- Deserialises an ALU packet (op_code, op_1, op_2) one bit per cycle and executes ADD/AND/OR/ROL/ROR. ROL/ROR are true rotates, replacing the old SHL/SHR semantics.
- Serialises back a result packet that carries carry and error status.
- Sits between the processor's serial link and the register write-back path.

---
 rtl/serial_alu_unit_pkg.sv | 27 ++
 rtl/serial_alu_unit_shift_register.sv | 25 ++
 rtl/serial_alu_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_alu_unit_pkg.sv
// ISA constants and result packet layout for the serial execution unit.
// Opcode values and the default register size are shared with the processor front-end.
package serial_alu_unit_pkg;

  localparam int REGISTER_SIZE = 32;
  localparam int OPCODE_SIZE   = 3;
  localparam int ALU_IN_BITS   = OPCODE_SIZE + 2 * REGISTER_SIZE;
  localparam int ALU_OUT_BITS  = REGISTER_SIZE + 2;

  // ROL/ROR take the encodings that used to belong to SHL/SHR.
  localparam logic [2:0] OP_ADD = 3'h0;
  localparam logic [2:0] OP_AND = 3'h1;
  localparam logic [2:0] OP_OR  = 3'h2;
  localparam logic [2:0] OP_MUL = 3'h3;
  localparam logic [2:0] OP_ROL = 3'h4;
  localparam logic [2:0] OP_ROR = 3'h5;
  localparam logic [2:0] OP_LW  = 3'h6;
  localparam logic [2:0] OP_SW  = 3'h7;

  // Result packet at the default register size; error is the last bit on the wire.
  typedef struct packed {
    logic                     error;
    logic                     carry;
    logic [REGISTER_SIZE-1:0] result;
  } alu_result_t;

endpackage

// File: rtl/serial_alu_unit_shift_register.sv
// Right-shifting register with parallel load and an LSB tap.
// Used as SIPO (shift in at MSB) and as PISO (load, then drain from the LSB).
module serial_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] data,
  output logic             lsb
);

  // Load has priority so a new packet is never corrupted by a stray shift.
  always_ff @(posedge clock) begin
    if (reset)         data <= '0;
    else if (load_en)  data <= load_data;
    else if (shift_en) data <= {shift_in, data[WIDTH-1:1]};
  end

  assign lsb = data[0];

endmodule

// File: rtl/serial_alu_unit.sv
// Serial ALU: receives {op_2, op_1, op_code} LSB-first, executes in one cycle,
// and returns {error, carry, result} LSB-first with a last-bit marker.
module serial_alu_unit
  import serial_alu_unit_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  output logic out_last,
  input  logic out_ready
);

  localparam int IN_BITS  = OPCODE_WIDTH + 2 * DATA_WIDTH;
  localparam int OUT_BITS = DATA_WIDTH + 2;
  localparam int AMT_W    = $clog2(DATA_WIDTH);
  localparam int CNT_W    = $clog2(IN_BITS);

  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_BITS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BITS - 1);

  localparam logic [1:0] ST_RECEIVE  = 2'd0;
  localparam logic [1:0] ST_EXECUTE  = 2'd1;
  localparam logic [1:0] ST_TRANSMIT = 2'd2;

  typedef struct packed {
    logic                  error;
    logic                  carry;
    logic [DATA_WIDTH-1:0] result;
  } result_t;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  in_xfer;
  logic                  out_xfer;

  logic [IN_BITS-1:0]    in_data;
  logic                  sipo_lsb;
  logic [OUT_BITS-1:0]   piso_data;
  logic                  piso_lsb;

  logic [OPCODE_WIDTH-1:0] op_code;
  logic [DATA_WIDTH-1:0]   op_1;
  logic [DATA_WIDTH-1:0]   op_2;
  logic [AMT_W-1:0]        amount;
  logic                    op_known;
  logic [DATA_WIDTH:0]     sum;
  logic [2*DATA_WIDTH-1:0] rot_l;
  logic [2*DATA_WIDTH-1:0] rot_r;
  result_t                 alu_res;

  assign in_ready  = (state == ST_RECEIVE);
  assign out_valid = (state == ST_TRANSMIT);
  assign out_bit   = piso_lsb;
  assign out_last  = out_valid && (cnt == OUT_LAST);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  serial_shift_register #(.WIDTH(IN_BITS)) u_sipo (
    .clock     (clock),
    .reset     (reset),
    .load_en   (1'b0),
    .load_data ('0),
    .shift_en  (in_xfer),
    .shift_in  (in_bit),
    .data      (in_data),
    .lsb       (sipo_lsb)
  );

  serial_shift_register #(.WIDTH(OUT_BITS)) u_piso (
    .clock     (clock),
    .reset     (reset),
    .load_en   (state == ST_EXECUTE),
    .load_data (alu_res),
    .shift_en  (out_xfer),
    .shift_in  (1'b0),
    .data      (piso_data),
    .lsb       (piso_lsb)
  );

  // Only the SIPO parallel word and the PISO tap feed the datapath.
  logic unused_taps;
  assign unused_taps = ^{sipo_lsb, piso_data};

  assign op_code  = in_data[OPCODE_WIDTH-1:0];
  assign op_1     = in_data[OPCODE_WIDTH +: DATA_WIDTH];
  assign op_2     = in_data[OPCODE_WIDTH+DATA_WIDTH +: DATA_WIDTH];
  assign amount   = op_2[AMT_W-1:0];
  // Codes beyond the 3-bit ISA space are always rejected.
  assign op_known = ((op_code >> 3) == '0);

  always_comb begin
    alu_res = '0;
    sum     = {1'b0, op_1} + {1'b0, op_2};
    // Rotating a doubled word keeps amount=0 well defined (no shift by DATA_WIDTH).
    rot_l   = {op_1, op_1} << amount;
    rot_r   = {op_1, op_1} >> amount;
    if (!op_known) begin
      alu_res.error = 1'b1;
    end else begin
      case (op_code[2:0])
        OP_ADD: begin
          alu_res.result = sum[DATA_WIDTH-1:0];
          alu_res.carry  = sum[DATA_WIDTH];
        end
        OP_AND:  alu_res.result = op_1 & op_2;
        OP_OR:   alu_res.result = op_1 | op_2;
        OP_ROL:  alu_res.result = rot_l[2*DATA_WIDTH-1:DATA_WIDTH];
        OP_ROR:  alu_res.result = rot_r[DATA_WIDTH-1:0];
        default: alu_res.error  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RECEIVE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RECEIVE: begin
          if (in_xfer) begin
            if (cnt == IN_LAST) begin
              cnt   <= '0;
              state <= ST_EXECUTE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_EXECUTE: state <= ST_TRANSMIT;
        ST_TRANSMIT: begin
          if (out_xfer) begin
            if (cnt == OUT_LAST) begin
              cnt   <= '0;
              state <= ST_RECEIVE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_RECEIVE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
